// File: rtl/div_arbiter_if.sv
// div_arbiter_if: bundles every non-clock/reset signal of div_arbiter.
//   slave  : view used by div_arbiter (takes requests and divider results,
//            drives grants, the response and the divider command).
//   master : view of the surrounding logic (requesters, response consumer,
//            shared divider).
// Signals:
//   req_valid/req_ready     per-requester request and one-hot accept
//   req_dividend/divisor    16-bit operands, slice i belongs to requester i
//   rsp_valid/rsp_ready     response handshake
//   rsp_id/quo/rem/err      response owner, quotient, remainder, div-by-zero
//   div_start, div_q/div_m  command to the shared divider
//   div_quo/div_rem         divider results
//   busy                    arbiter not in IDLE
interface div_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][15:0] req_dividend;
  logic [NREQ-1:0][15:0] req_divisor;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [15:0]           rsp_quo;
  logic [15:0]           rsp_rem;
  logic                  rsp_err;
  logic                  div_start;
  logic [15:0]           div_q;
  logic [15:0]           div_m;
  logic [15:0]           div_quo;
  logic [15:0]           div_rem;
  logic                  busy;

  modport slave (
    input  req_valid, req_dividend, req_divisor, rsp_ready, div_quo, div_rem,
    output req_ready, rsp_valid, rsp_id, rsp_quo, rsp_rem, rsp_err,
           div_start, div_q, div_m, busy
  );

  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ready, div_quo, div_rem,
    input  req_ready, rsp_valid, rsp_id, rsp_quo, rsp_rem, rsp_err,
           div_start, div_q, div_m, busy
  );
endinterface

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter sharing one fixed-latency 16-bit divider
// among NREQ requesters. One operation is in flight at a time:
//   IDLE -> ISSUE (div_start pulse) -> WAIT (DIV_LAT-1 .. 0) -> RESP.
// After reset the block sits in DRAIN for DIV_LAT cycles so that a divider
// operation started before reset finishes before a new one is launched.
//
// Ports:
//   sys_clk   rising-edge clock
//   sys_rst   synchronous active-high reset
//   bus       div_arbiter_if.slave (requests, response, divider command)
//
// Optional feature macro: DIV_ZERO_CHECK_EN
//   defined   : zero divisors bypass the divider, answer next cycle with
//               quo=16'hFFFF, rem=dividend, rsp_err=1
//   undefined : rsp_err tied 0, zero divisors go through the divider
module div_arbiter #(
  parameter int NREQ    = 4,
  parameter int DIV_LAT = 50
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  div_arbiter_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(DIV_LAT + 1);

  typedef enum logic [2:0] {DRAIN, IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [IDW-1:0] last_q;
  logic [IDW-1:0] id_q;
  logic [15:0]    q_q, m_q;
  logic [15:0]    quo_q, rem_q;
  logic           rsp_valid_q;
  logic           start_q;
  logic           busy_q;
`ifdef DIV_ZERO_CHECK_EN
  logic           err_q;
`endif

  // Round-robin pick: scan from farthest to nearest of last_q+1 so the
  // nearest valid requester is the one left standing.
  logic           gnt_vld;
  logic [IDW-1:0] gnt_idx;
  int             idx;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = int'(last_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
  end

  // Accept is combinational so the requester sees it in the grant cycle.
  logic [NREQ-1:0] rdy;
  always_comb begin
    rdy = '0;
    if (state_q == IDLE && gnt_vld) rdy[gnt_idx] = 1'b1;
  end

  logic [15:0] gnt_dvd, gnt_dvs;
  assign gnt_dvd = bus.req_dividend[gnt_idx];
  assign gnt_dvs = bus.req_divisor[gnt_idx];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= DRAIN;
      cnt_q       <= CW'(DIV_LAT);
      last_q      <= IDW'(NREQ - 1);
      id_q        <= '0;
      q_q         <= '0;
      m_q         <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      rsp_valid_q <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b1;
`ifdef DIV_ZERO_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        DRAIN: begin
          // cnt_q runs DIV_LAT..1, one DRAIN cycle per value
          if (cnt_q <= CW'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        IDLE: begin
          if (gnt_vld) begin
            id_q   <= gnt_idx;
            q_q    <= gnt_dvd;
            m_q    <= gnt_dvs;
            busy_q <= 1'b1;
`ifdef DIV_ZERO_CHECK_EN
            if (gnt_dvs == 16'h0000) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              quo_q       <= 16'hFFFF;
              rem_q       <= gnt_dvd;
              err_q       <= 1'b1;
            end else begin
              state_q <= ISSUE;
              start_q <= 1'b1;
              err_q   <= 1'b0;
            end
`else
            state_q <= ISSUE;
            start_q <= 1'b1;
`endif
          end
        end
        ISSUE: begin
          start_q <= 1'b0;
          cnt_q   <= CW'(DIV_LAT - 1);
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q == '0) begin
            quo_q       <= bus.div_quo;
            rem_q       <= bus.div_rem;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            last_q      <= id_q;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= DRAIN;
          cnt_q   <= CW'(DIV_LAT);
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = rdy;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_quo   = quo_q;
  assign bus.rsp_rem   = rem_q;
`ifdef DIV_ZERO_CHECK_EN
  assign bus.rsp_err   = err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif
  assign bus.div_start = start_q;
  assign bus.div_q     = q_q;
  assign bus.div_m     = m_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed + randomized bench for div_arbiter. A
// transaction-level model predicts the round-robin winner, response latency
// and result; a behavioural divider answers exactly DIV_LAT cycles after
// div_start using the live div_q/div_m and drives junk at any other time.
module tb_div_arbiter;
  localparam int NREQ    = 4;
  localparam int DIV_LAT = 50;
`ifdef DIV_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  div_arbiter_if #(.NREQ(NREQ)) bus ();

  div_arbiter #(.NREQ(NREQ), .DIV_LAT(DIV_LAT)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  // behavioural shared divider
  bit dact = 1'b0;
  int dcnt = 0;
  always @(posedge sys_clk) begin
    if (bus.div_start) begin
      dact <= 1'b1;
      dcnt <= DIV_LAT - 1;
    end else if (dact) begin
      if (dcnt == 0) dact <= 1'b0;
      else           dcnt <= dcnt - 1;
    end
  end
  assign bus.div_quo = (dact && dcnt == 0) ?
                       ((bus.div_m == 16'h0) ? 16'hFFFF : bus.div_q / bus.div_m) : 16'hBAD0;
  assign bus.div_rem = (dact && dcnt == 0) ?
                       ((bus.div_m == 16'h0) ? bus.div_q : bus.div_q % bus.div_m) : 16'hBAD1;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          last_g;
  logic [15:0] dvd [NREQ];
  logic [15:0] dvs [NREQ];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic finish_tb();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive_ops();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_dividend[i] = dvd[i];
      bus.req_divisor[i]  = dvs[i];
    end
    #1;
  endtask

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  // Current cycle is the first DRAIN cycle (reset just released).
  task automatic drain_check();
    bit bad = 1'b0;
    bus.req_valid = '1;
    #1;
    chk("rst_rsp_id",  32'(bus.rsp_id), 32'd0);
    chk("rst_rsp_quo", 32'(bus.rsp_quo), 32'd0);
    chk("rst_rsp_rem", 32'(bus.rsp_rem), 32'd0);
    chk("rst_div_q",   32'(bus.div_q), 32'd0);
    chk("rst_div_m",   32'(bus.div_m), 32'd0);
    for (int i = 0; i < DIV_LAT; i++) begin
      if (i > 0) step();
      if (bus.busy !== 1'b1 || bus.req_ready !== '0 || bus.rsp_valid !== 1'b0 ||
          bus.div_start !== 1'b0 || bus.rsp_err !== 1'b0) bad = 1'b1;
    end
    chk("drain_hold", 32'(bad), 32'd0);
    last_g = NREQ - 1;
  endtask

  // Next cycle must be IDLE. Runs one full operation with 'stall' cycles of
  // rsp_ready low before the response is taken.
  task automatic do_op(input logic [NREQ-1:0] v, input int stall);
    int g, lat, nstart, st_cyc;
    bit ee, bad_rdy, bad_hold;
    logic [15:0] eq, er;
    logic [NREQ-1:0] exp_rdy;
    step();
    bus.req_valid = v;
    bus.rsp_ready = 1'b0;
    drive_ops();
    g = rr_pick(last_g, v);
    exp_rdy = '0;
    exp_rdy[g] = 1'b1;
    chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("grant", 32'(bus.req_ready), 32'(exp_rdy));
    ee = ZCHK && (dvs[g] == 16'h0);
    eq = (dvs[g] == 16'h0) ? 16'hFFFF : dvd[g] / dvs[g];
    er = (dvs[g] == 16'h0) ? dvd[g]   : dvd[g] % dvs[g];
    lat = 0; nstart = 0; st_cyc = 0; bad_rdy = 1'b0;
    forever begin
      step();
      lat++;
      if (bus.div_start) begin nstart++; st_cyc = lat; end
      if (bus.rsp_valid) break;
      if (bus.req_ready !== '0 || bus.busy !== 1'b1) bad_rdy = 1'b1;
      if (lat > DIV_LAT + 8) begin
        chk("rsp_timeout", 32'(lat), 32'(DIV_LAT + 2));
        finish_tb();
      end
    end
    chk("latency", 32'(lat), ee ? 32'd1 : 32'(DIV_LAT + 2));
    chk("start_count", 32'(nstart), ee ? 32'd0 : 32'd1);
    chk("start_cycle", 32'(st_cyc), ee ? 32'd0 : 32'd1);
    chk("ready_while_busy", 32'(bad_rdy), 32'd0);
    chk("rsp_id",  32'(bus.rsp_id), 32'(g));
    chk("rsp_quo", 32'(bus.rsp_quo), 32'(eq));
    chk("rsp_rem", 32'(bus.rsp_rem), 32'(er));
    chk("rsp_err", 32'(bus.rsp_err), 32'(ee));
    bad_hold = 1'b0;
    for (int s = 0; s < stall; s++) begin
      step();
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== g[1:0] || bus.rsp_quo !== eq ||
          bus.rsp_rem !== er || bus.rsp_err !== ee || bus.req_ready !== '0 ||
          bus.div_start !== 1'b0) bad_hold = 1'b1;
    end
    if (stall > 0) chk("stall_hold", 32'(bad_hold), 32'd0);
    bus.rsp_ready = 1'b1;
    last_g = g;
  endtask

  initial begin
    bus.req_valid    = '0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    bus.rsp_ready    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin dvd[i] = '0; dvs[i] = 16'd1; end
    last_g = NREQ - 1;

    step();
    step();
    sys_rst = 1'b0;
    drain_check();

    // req0 and req2 together: req0 first (100/7), then req2 (1000/10)
    dvd[0] = 16'd100;  dvs[0] = 16'd7;
    dvd[2] = 16'd1000; dvs[2] = 16'd10;
    do_op(4'b0101, 0);
    do_op(4'b0101, 2);

    // req1 55/0 with a 10-cycle response stall
    dvd[1] = 16'd55; dvs[1] = 16'd0;
    do_op(4'b0010, 10);

    // reset during the 20th WAIT cycle discards the operation
    step();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0001;
    dvd[0] = 16'd100; dvs[0] = 16'd7;
    drive_ops();
    chk("rst_test_grant", 32'(bus.req_ready), 32'd1);
    bus.req_valid = '0;
    for (int i = 0; i < 21; i++) step();   // ISSUE + 20 WAIT cycles
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    drain_check();

    dvd[3] = 16'd9; dvs[3] = 16'd3;
    do_op(4'b1000, 0);

    // all requesters continuously valid: 0,1,2,3,0,1,2,3
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        dvd[i] = 16'($urandom);
        dvs[i] = 16'($urandom_range(1, 300));
      end
      do_op(4'hF, int'($urandom_range(0, 2)));
      chk("rr_order", 32'(last_g), 32'(n % NREQ));
    end

    // random traffic
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        dvd[i] = 16'($urandom);
        case ($urandom_range(0, 3))
          0:       dvs[i] = 16'h0;
          1:       dvs[i] = 16'($urandom_range(1, 15));
          default: dvs[i] = 16'($urandom);
        endcase
      end
      do_op(4'($urandom_range(1, 15)), int'($urandom_range(0, 4)));
    end

    step();
    bus.rsp_ready = 1'b0;
    chk("final_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    finish_tb();
  end
endmodule
